// File: rtl/axi_rom_bridge.sv
// AXI4 read-only slave that turns read bursts into one-word-per-beat ROM fetches.
// Define AXI_ROM_WRAP_EN to enable true WRAP bursts; otherwise WRAP behaves as INCR.
module axi_rom_bridge #(
  parameter logic [3:0] AXI_ID     = 4'd0,
  parameter int         ROM_ADDR_W = 14
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  axi_arvalid_i,
  output logic                  axi_arready_o,
  input  logic [31:0]           axi_araddr_i,
  input  logic [3:0]            axi_arid_i,
  input  logic [7:0]            axi_arlen_i,
  input  logic [1:0]            axi_arburst_i,
  output logic                  axi_rvalid_o,
  input  logic                  axi_rready_i,
  output logic [31:0]           axi_rdata_o,
  output logic [1:0]            axi_rresp_o,
  output logic [3:0]            axi_rid_o,
  output logic                  axi_rlast_o,
  output logic                  rom_rd_o,
  output logic [ROM_ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]           rom_data_i
);

  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_RSVD  = 2'b11;
`ifdef AXI_ROM_WRAP_EN
  localparam logic [1:0] BURST_WRAP  = 2'b10;
`endif

  state_t                  state_q, state_d;
  logic [ROM_ADDR_W-1:0]   addr_q, addr_next;
  logic [3:0]              id_q;
  logic [7:0]              len_q;
  logic [1:0]              burst_q;
  logic [7:0]              beat_q;
  logic                    err_q, err_d;
  logic                    ar_hs, r_hs, last_beat;

  // Address bits outside the ROM window and the ID parameter have no effect.
  logic unused_bits;
  assign unused_bits = &{1'b0, axi_araddr_i[31:ROM_ADDR_W+2], axi_araddr_i[1:0], AXI_ID};

  assign ar_hs     = (state_q == IDLE) && axi_arvalid_i;
  assign r_hs      = (state_q == DATA) && axi_rready_i;
  assign last_beat = (beat_q == len_q);

  // A request is flagged as an error for its whole lifetime when it is accepted.
  always_comb begin
    err_d = (axi_arburst_i == BURST_RSVD);
`ifdef AXI_ROM_WRAP_EN
    if ((axi_arburst_i == BURST_WRAP) &&
        !(axi_arlen_i inside {8'd1, 8'd3, 8'd7, 8'd15}))
      err_d = 1'b1;
`endif
  end

  always_comb begin
    addr_next = addr_q + {{(ROM_ADDR_W-1){1'b0}}, 1'b1};
    if (burst_q == BURST_FIXED)
      addr_next = addr_q;
`ifdef AXI_ROM_WRAP_EN
    // WRAP lengths are 2^n-1, so len_q doubles as the in-window word mask.
    else if (burst_q == BURST_WRAP && !err_q)
      addr_next = (addr_q & ~ROM_ADDR_W'(len_q)) |
                  ((addr_q + {{(ROM_ADDR_W-1){1'b0}}, 1'b1}) & ROM_ADDR_W'(len_q));
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    axi_arready_o = 1'b0;
    axi_rvalid_o  = 1'b0;
    axi_rdata_o   = 32'd0;
    axi_rresp_o   = 2'b00;
    axi_rid_o     = 4'd0;
    axi_rlast_o   = 1'b0;
    rom_rd_o      = 1'b0;
    rom_addr_o    = addr_q;
    case (state_q)
      IDLE: begin
        axi_arready_o = 1'b1;
        if (axi_arvalid_i) state_d = FETCH;
      end
      FETCH: begin
        rom_rd_o = !err_q;
        state_d  = DATA;
      end
      DATA: begin
        axi_rvalid_o = 1'b1;
        axi_rdata_o  = err_q ? 32'd0 : rom_data_i;
        axi_rresp_o  = err_q ? 2'b10 : 2'b00;
        axi_rid_o    = id_q;
        axi_rlast_o  = last_beat;
        if (axi_rready_i) state_d = last_beat ? IDLE : FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_q  <= '0;
      id_q    <= 4'd0;
      len_q   <= 8'd0;
      burst_q <= 2'b00;
      beat_q  <= 8'd0;
      err_q   <= 1'b0;
    end else if (ar_hs) begin
      addr_q  <= axi_araddr_i[ROM_ADDR_W+1:2];
      id_q    <= axi_arid_i;
      len_q   <= axi_arlen_i;
      burst_q <= axi_arburst_i;
      beat_q  <= 8'd0;
      err_q   <= err_d;
    end else if (r_hs && !last_beat) begin
      addr_q <= addr_next;
      beat_q <= beat_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_axi_rom_bridge.sv
// Self-checking bench for axi_rom_bridge: burst-level reference model plus a behavioural ROM.
// Honours AXI_ROM_WRAP_EN the same way the design does.
module tb_axi_rom_bridge;

  localparam int RW = 14;

  logic          clk = 1'b0;
  logic          rst;
  logic          arvalid;
  logic          arready;
  logic [31:0]   araddr;
  logic [3:0]    arid;
  logic [7:0]    arlen;
  logic [1:0]    arburst;
  logic          rvalid;
  logic          rready;
  logic [31:0]   rdata;
  logic [1:0]    rresp;
  logic [3:0]    rid;
  logic          rlast;
  logic          rom_rd;
  logic [RW-1:0] rom_addr;
  logic [31:0]   rom_data = 32'd0;

  int n_compared   = 0;
  int n_mismatched = 0;
  int rd_pulses    = 0;

  axi_rom_bridge #(.AXI_ID(4'd0), .ROM_ADDR_W(RW)) dut (
    .clk_i(clk), .rst_i(rst),
    .axi_arvalid_i(arvalid), .axi_arready_o(arready), .axi_araddr_i(araddr),
    .axi_arid_i(arid), .axi_arlen_i(arlen), .axi_arburst_i(arburst),
    .axi_rvalid_o(rvalid), .axi_rready_i(rready), .axi_rdata_o(rdata),
    .axi_rresp_o(rresp), .axi_rid_o(rid), .axi_rlast_o(rlast),
    .rom_rd_o(rom_rd), .rom_addr_o(rom_addr), .rom_data_i(rom_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [RW-1:0] a);
    return {a[7:0], ~a[7:0], 2'b10, a} ^ 32'hC3A5_1E69;
  endfunction

  // Behavioural ROM: data appears the cycle after a read strobe and is held.
  always @(posedge clk) begin
    if (rom_rd) begin
      rom_data  <= rom_word(rom_addr);
      rd_pulses <= rd_pulses + 1;
    end
  end

  function automatic logic exp_err(input logic [7:0] len, input logic [1:0] burst);
    if (burst == 2'b11) return 1'b1;
`ifdef AXI_ROM_WRAP_EN
    if (burst == 2'b10 && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Byte address of beat i by AXI burst rules, reduced to the aliased ROM word index.
  function automatic logic [RW-1:0] exp_word(input logic [31:0] addr, input logic [7:0] len,
                                              input logic [1:0] burst, input int i);
    logic [31:0] start, a;
`ifdef AXI_ROM_WRAP_EN
    logic [31:0] size, base;
`endif
    start = {addr[31:2], 2'b00};
    a     = start + 32'(i) * 32'd4;
    if (burst == 2'b00) a = start;
`ifdef AXI_ROM_WRAP_EN
    if (burst == 2'b10) begin
      size = (32'(len) + 32'd1) * 32'd4;
      base = start - (start % size);
      a    = base + ((start - base + 32'(i) * 32'd4) % size);
    end
`endif
    return a[RW+1:2];
  endfunction

  task automatic run_burst(input logic [31:0] addr, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, input int stall_beat, input int stall_cycles,
                           input bit rand_stall, input int abort_beat);
    logic          err;
    logic [RW-1:0] w;
    logic [31:0]   d;
    logic [1:0]    resp;
    int            pulses0, s;
    err     = exp_err(len, burst);
    pulses0 = rd_pulses;
    @(negedge clk);
    n_compared++;
    if (arready !== 1'b1) begin
      n_mismatched++; $display("[TB] FAIL arready_idle: got %b want 1", arready);
    end
    arvalid = 1'b1; araddr = addr; arid = id; arlen = len; arburst = burst;
    @(negedge clk);
    arvalid = 1'b0; araddr = $urandom; arid = 4'($urandom); arlen = 8'($urandom);
    arburst = 2'($urandom);
    for (int i = 0; i <= int'(len); i++) begin
      w    = exp_word(addr, len, burst, i);
      d    = err ? 32'd0 : rom_word(w);
      resp = err ? 2'b10 : 2'b00;
      n_compared++;
      if (rom_rd !== !err || rvalid !== 1'b0 || arready !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL fetch_ctrl beat %0d: rd/rvalid/arready got %b%b%b want %b00",
                 i, rom_rd, rvalid, arready, !err);
      end
      if (!err) begin
        n_compared++;
        if (rom_addr !== w) begin
          n_mismatched++;
          $display("[TB] FAIL rom_addr beat %0d: got %0d want %0d", i, rom_addr, w);
        end
      end
      @(negedge clk);
      n_compared++;
      if (rvalid !== 1'b1 || rdata !== d || rresp !== resp || rid !== id ||
          rlast !== (i == int'(len)) || arready !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL data_beat %0d: v=%b d=%h r=%b id=%h last=%b got, want v=1 d=%h r=%b id=%h last=%b",
                 i, rvalid, rdata, rresp, rid, rlast, d, resp, id, i == int'(len));
      end
      if (i == abort_beat) begin
        #2 rst = 1'b1;
        #1;
        n_compared++;
        if (rvalid !== 1'b0 || arready !== 1'b1) begin
          n_mismatched++;
          $display("[TB] FAIL async_reset: rvalid=%b arready=%b want 0/1", rvalid, arready);
        end
        return;
      end
      s = (i == stall_beat) ? stall_cycles : (rand_stall ? int'($urandom_range(0, 2)) : 0);
      for (int k = 0; k < s; k++) begin
        @(negedge clk);
        n_compared++;
        if (rvalid !== 1'b1 || rdata !== d || rresp !== resp || rid !== id ||
            rlast !== (i == int'(len)) || rom_rd !== 1'b0) begin
          n_mismatched++;
          $display("[TB] FAIL stall_hold beat %0d: v=%b d=%h last=%b rd=%b want v=1 d=%h last=%b rd=0",
                   i, rvalid, rdata, rlast, rom_rd, d, i == int'(len));
        end
      end
      rready = 1'b1;
      @(negedge clk);
      rready = 1'b0;
    end
    n_compared++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL burst_end: arready=%b rvalid=%b want 1/0", arready, rvalid);
    end
    n_compared++;
    if (rd_pulses - pulses0 !== (err ? 0 : int'(len) + 1)) begin
      n_mismatched++;
      $display("[TB] FAIL rd_pulse_count: got %0d want %0d", rd_pulses - pulses0,
               err ? 0 : int'(len) + 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; arvalid = 1'b0; araddr = 32'd0; arid = 4'd0; arlen = 8'd0; arburst = 2'b01;
    rready = 1'b0;
    repeat (3) @(negedge clk);
    n_compared++;
    if (arready !== 1'b1 || rvalid !== 1'b0 || rlast !== 1'b0 || rresp !== 2'b00 ||
        rid !== 4'd0 || rdata !== 32'd0 || rom_rd !== 1'b0 || rom_addr !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: ar=%b v=%b last=%b resp=%b id=%h d=%h rd=%b a=%h want 1 0 0 00 0 0 0 0",
               arready, rvalid, rlast, rresp, rid, rdata, rom_rd, rom_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    run_burst(32'h8000_0010, 4'd3, 8'd0, 2'b01, -1, 0, 1'b0, -1);
  endtask

  task automatic test_incr_burst();
    run_burst(32'h0000_0000, 4'd5, 8'd7, 2'b01, -1, 0, 1'b0, -1);
  endtask

  task automatic test_fixed();
    run_burst(32'h0000_0026, 4'd4, 8'd3, 2'b00, -1, 0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    run_burst(32'h0000_0100, 4'd9, 8'd3, 2'b01, 1, 5, 1'b0, -1);
  endtask

  task automatic test_wrap();
    run_burst(32'h0000_0038, 4'd2, 8'd3, 2'b10, -1, 0, 1'b0, -1);
    run_burst(32'h0000_0074, 4'd1, 8'd7, 2'b10, -1, 0, 1'b0, -1);
    run_burst(32'h0000_0038, 4'd6, 8'd2, 2'b10, -1, 0, 1'b0, -1);
  endtask

  task automatic test_reserved();
    run_burst(32'h0000_0040, 4'd12, 8'd1, 2'b11, -1, 0, 1'b0, -1);
  endtask

  task automatic test_long_burst();
    run_burst(32'h0000_FFF0, 4'd7, 8'd255, 2'b01, -1, 0, 1'b0, -1);
  endtask

  task automatic test_reset_mid_burst();
    int pulses0;
    run_burst(32'h0000_0200, 4'd6, 8'd7, 2'b01, -1, 0, 1'b0, 2);
    pulses0 = rd_pulses;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      n_compared++;
      if (rvalid !== 1'b0 || arready !== 1'b1 || rom_rd !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL no_resume: rvalid=%b arready=%b rd=%b want 0/1/0", rvalid, arready, rom_rd);
      end
    end
    n_compared++;
    if (rd_pulses !== pulses0) begin
      n_mismatched++;
      $display("[TB] FAIL post_reset_pulses: got %0d want %0d", rd_pulses, pulses0);
    end
    run_burst(32'h0000_1234, 4'd1, 8'd0, 2'b01, -1, 0, 1'b0, -1);
  endtask

  task automatic test_random();
    logic [7:0] len;
    for (int n = 0; n < 30; n++) begin
      len = (n % 10 == 9) ? 8'($urandom_range(16, 40)) : 8'($urandom_range(0, 15));
      run_burst($urandom, 4'($urandom), len, 2'($urandom_range(0, 3)), -1, 0, 1'b1, -1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_incr_burst();
    test_fixed();
    test_backpressure();
    test_wrap();
    test_reserved();
    test_long_burst();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
